// File: rtl/counter_bank_arbiter.sv
// Bank of small up-counters fed by one round-robin-arbitrated incrementer,
// with a sequenced sweep-clear FSM. One increment is granted per cycle at most.
module counter_bank_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] count_q;
  logic             ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
      if (&count_q) ovf_q <= 1'b1;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
endmodule

module counter_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] clr_i,
  input  logic               sweep_start_i,
  input  logic [IW-1:0]      rd_sel_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] overflow_o,
  output logic               busy_o
);
  localparam int NPAD = 1 << IW;

  typedef enum logic {RUN, SWEEP} state_e;

  state_e                         state_q, state_d;
  logic [IW-1:0]                  ptr_q, ptr_d;
  logic [IW-1:0]                  k_q, k_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic [NUM_REQ-1:0]             elig, lane_clr;
  logic [NUM_REQ-1:0][WIDTH-1:0]  count;
  logic [NPAD-1:0][WIDTH-1:0]     rd_pad;
  logic [IW-1:0]                  win;
  logic                           found;

  // A clear on index i removes it from this cycle's arbitration entirely.
  assign elig = (state_q == RUN && enable_i) ? (req_i & ~clr_i) : '0;

  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    if (found) begin
      grant_d = NUM_REQ'(1) << win;
      ptr_d   = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      RUN: begin
        if (sweep_start_i) begin
          state_d = SWEEP;
          k_d     = '0;
        end
      end
      SWEEP: begin
        if (k_q == IW'(NUM_REQ - 1)) begin
          state_d = RUN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= RUN;
      ptr_q   <= '0;
      k_q     <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      k_q     <= k_d;
      grant_q <= grant_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_clr
    assign lane_clr[g] = clr_i[g] | ((state_q == SWEEP) && (k_q == IW'(g)));
  end

  counter_bank_lane #(.WIDTH(WIDTH)) u_lane [NUM_REQ-1:0] (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .inc_i   (grant_d),
    .clr_i   (lane_clr),
    .count_o (count),
    .ovf_o   (overflow_o)
  );

  // Unused select codes (rd_sel >= NUM_REQ) read back as zero.
  for (genvar g = 0; g < NPAD; g++) begin : g_rd
    if (g < NUM_REQ) begin : g_live
      assign rd_pad[g] = count[g];
    end else begin : g_zero
      assign rd_pad[g] = '0;
    end
  end

  assign rd_data_o = rd_pad[rd_sel_i];
  assign grant_o   = grant_q;
  assign busy_o    = (state_q == SWEEP);
endmodule

// File: tb/tb_counter_bank_arbiter.sv
// Directed bench for counter_bank_arbiter (NUM_REQ=4, WIDTH=4).
module tb_counter_bank_arbiter;
  logic       clock_i = 1'b0;
  logic       reset_i, enable_i, sweep_start_i;
  logic [3:0] req_i, clr_i;
  logic [1:0] rd_sel_i;
  logic [3:0] rd_data_o, grant_o, overflow_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  counter_bank_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .clr_i         (clr_i),
    .sweep_start_i (sweep_start_i),
    .rd_sel_i      (rd_sel_i),
    .rd_data_o     (rd_data_o),
    .grant_o       (grant_o),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int idx, input int exp);
    rd_sel_i = 2'(idx);
    #1;
    chk(tag, 32'(rd_data_o), 32'(exp));
  endtask

  task automatic do_reset;
    reset_i = 1'b1; enable_i = 1'b1; sweep_start_i = 1'b0;
    req_i = '0; clr_i = '0; rd_sel_i = '0;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    int orig [4];

    // reset state
    do_reset();
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    for (int j = 0; j < 4; j++) chk_cnt("rst_cnt", j, 0);

    // single requester: 16 grants wrap count0 and set overflow[0]
    req_i = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("solo_grant", 32'(grant_o), 1);
      chk_cnt("solo_cnt0", 0, i % 16);
      chk("solo_ovf", 32'(overflow_o), (i == 16) ? 1 : 0);
    end
    for (int j = 1; j < 4; j++) chk_cnt("solo_other", j, 0);

    // all requesting: strict rotation 0,1,2,3
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_grant", 32'(grant_o), 32'(1) << (i % 4));
    end
    for (int j = 0; j < 4; j++) chk_cnt("rr_cnt", j, 2);
    chk("rr_ovf", 32'(overflow_o), 0);
    enable_i = 1'b0;
    tick();
    chk("dis_grant", 32'(grant_o), 0);
    chk_cnt("dis_cnt0", 0, 2);
    enable_i = 1'b1;

    // ptr=2 with req 1001 alternates 3,0
    do_reset();
    req_i = 4'b0010;
    tick();
    req_i = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_grant", 32'(grant_o), (i % 2 == 0) ? 32'h8 : 32'h1);
    end

    // clear beats same-cycle increment
    do_reset();
    req_i = 4'b0010;
    repeat (5) tick();
    chk_cnt("clr_pre", 1, 5);
    clr_i = 4'b0010;
    tick();
    chk_cnt("clr_cnt1", 1, 0);
    chk("clr_grant", 32'(grant_o), 0);
    chk("clr_ovf", 32'(overflow_o), 0);
    clr_i = 4'b0000;
    tick();
    chk("clr_next_grant", 32'(grant_o), 32'h2);
    chk_cnt("clr_next_cnt1", 1, 1);

    // preload 3,7,1,9 then sweep with all requesting
    do_reset();
    req_i = 4'b0001; repeat (3) tick();
    req_i = 4'b0010; repeat (7) tick();
    req_i = 4'b0100; repeat (1) tick();
    req_i = 4'b1000; repeat (9) tick();
    chk_cnt("pre_cnt0", 0, 3);
    chk_cnt("pre_cnt1", 1, 7);
    chk_cnt("pre_cnt2", 2, 1);
    chk_cnt("pre_cnt3", 3, 9);
    // ptr is 0 here; the start cycle still arbitrates, granting idx0 -> 4
    req_i = 4'b1111;
    sweep_start_i = 1'b1;
    tick();
    sweep_start_i = 1'b0;
    chk("swp_start_busy", 32'(busy_o), 1);
    chk("swp_start_grant", 32'(grant_o), 1);
    orig[0] = 4; orig[1] = 7; orig[2] = 1; orig[3] = 9;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("swp_busy", 32'(busy_o), (s < 3) ? 1 : 0);
      chk("swp_grant", 32'(grant_o), 0);
      for (int j = 0; j < 4; j++) chk_cnt("swp_cnt", j, (j <= s) ? 0 : orig[j]);
    end
    tick();
    chk("swp_resume1", 32'(grant_o), 32'h2);
    tick();
    chk("swp_resume2", 32'(grant_o), 32'h4);

    // reset during the second sweep cycle
    do_reset();
    req_i = 4'b1000; repeat (16) tick();
    req_i = 4'b0100; repeat (2) tick();
    chk("mid_pre_ovf", 32'(overflow_o), 32'h8);
    chk_cnt("mid_pre_cnt2", 2, 2);
    req_i = 4'b0000;
    sweep_start_i = 1'b1;
    tick();
    sweep_start_i = 1'b0;
    tick();
    chk("mid_busy2", 32'(busy_o), 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_grant", 32'(grant_o), 0);
    chk("mid_ovf", 32'(overflow_o), 0);
    for (int j = 0; j < 4; j++) chk_cnt("mid_cnt", j, 0);
    req_i = 4'b1111;
    tick();
    chk("mid_ptr0", 32'(grant_o), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
